op_stack: RTL and testbench

Operand/return stack of the AZ10 stack processor, sitting directly upstream of the program counter. It holds data words pushed by the datapath and exposes the top word combinationally (show-ahead) on `stk_data_out`, which the PC samples as a branch target. The pop strobe from the PC is level-held for several cycles and may float. The stack therefore acts on the rising edge of each request rather than on its level.

---
 rtl/az10_pkg.sv | 17 +
 rtl/op_stack_edge_det.sv | 22 ++
 rtl/op_stack.sv | 135 +++++++++++++
 tb/tb_op_stack.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/az10_pkg.sv
// Shared AZ10 constants: word width, default stack depth and the resolved
// stack-operation encoding listed in priority order.
package az10_pkg;

  localparam int DATA_LEN  = 8;
  localparam int STK_DEPTH = 16;

  typedef enum logic [2:0] {
    STK_NOP  = 3'd0,
    STK_PUSH = 3'd1,
    STK_POP  = 3'd2,
    STK_REPL = 3'd3,
    STK_DUP  = 3'd4,
    STK_SWAP = 3'd5
  } stk_op_e;

endpackage

// File: rtl/op_stack_edge_det.sv
// Rising-edge detector: fires for the one cycle where the request is 1 and its
// history is 0; only a clean 1 counts, so a floating (z/x) request reads as 0.
module edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic req,
  output logic fire
);

  logic req_one;
  logic hist_q, hist_d;

  assign req_one = (req === 1'b1);
  assign hist_d  = req_one;
  assign fire    = req_one & ~hist_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist_q <= 1'b0;
    else       hist_q <= hist_d;
  end

endmodule

// File: rtl/op_stack.sv
// AZ10 operand/return stack: edge-triggered push/pop/dup/swap, show-ahead top and NOS,
// results visible after the firing edge; no backpressure. Optional guard: STK_GUARD_EN.
module op_stack #(
  parameter int DATA_LEN  = az10_pkg::DATA_LEN,
  parameter int STK_DEPTH = az10_pkg::STK_DEPTH
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           stk_push,
  input  logic                           stk_pop,
  input  logic                           stk_dup,
  input  logic                           stk_swap,
  input  logic [DATA_LEN-1:0]            stk_data_in,
  output logic [DATA_LEN-1:0]            stk_data_out,
  output logic [DATA_LEN-1:0]            stk_nos,
  output logic [$clog2(STK_DEPTH):0]     stk_count,
  output logic                           stk_empty,
  output logic                           stk_full,
  output logic                           stk_err
);

  import az10_pkg::*;

  localparam int AW  = $clog2(STK_DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STK_DEPTH);

  logic push_fire, pop_fire, dup_fire, swap_fire;
  logic push_go, pop_go, dup_go, swap_go;
  logic arm_q, arm_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [DATA_LEN-1:0] mem_q [STK_DEPTH];
  logic [DATA_LEN-1:0] mem_d [STK_DEPTH];
  logic [AW-1:0] idx0, idx1, idx2;
  stk_op_e op;
  logic op_ok;

  edge_det u_push (.clk(clk), .rstn(rstn), .req(stk_push), .fire(push_fire));
  edge_det u_pop  (.clk(clk), .rstn(rstn), .req(stk_pop),  .fire(pop_fire));
  edge_det u_dup  (.clk(clk), .rstn(rstn), .req(stk_dup),  .fire(dup_fire));
  edge_det u_swap (.clk(clk), .rstn(rstn), .req(stk_swap), .fire(swap_fire));

  // The first edge after reset only loads history, so a level held through
  // reset release is not mistaken for a fresh request.
  assign arm_d   = 1'b1;
  assign push_go = push_fire & arm_q;
  assign pop_go  = pop_fire  & arm_q;
  assign dup_go  = dup_fire  & arm_q;
  assign swap_go = swap_fire & arm_q;

  assign idx0 = sp_q[AW-1:0];
  assign idx1 = sp_q[AW-1:0] - AW'(1);
  assign idx2 = sp_q[AW-1:0] - AW'(2);

  always_comb begin
    op = STK_NOP;
    if (push_go && pop_go) op = (sp_q == '0) ? STK_PUSH : STK_REPL;
    else if (push_go)      op = STK_PUSH;
    else if (pop_go)       op = STK_POP;
    else if (dup_go)       op = STK_DUP;
    else if (swap_go)      op = STK_SWAP;
  end

`ifdef STK_GUARD_EN
  logic err_q, err_d;

  always_comb begin
    op_ok = 1'b1;
    unique case (op)
      STK_PUSH: op_ok = (sp_q != SP_FULL);
      STK_POP:  op_ok = (sp_q != '0);
      STK_DUP:  op_ok = (sp_q != '0) && (sp_q != SP_FULL);
      STK_SWAP: op_ok = (sp_q >= SPW'(2));
      default:  op_ok = 1'b1;
    endcase
    err_d = err_q | ~op_ok;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign stk_err = err_q;
`else
  assign op_ok   = 1'b1;
  assign stk_err = 1'b0;
`endif

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (op_ok) begin
      unique case (op)
        STK_PUSH: begin
          mem_d[idx0] = stk_data_in;
          sp_d        = sp_q + SPW'(1);
        end
        STK_REPL: mem_d[idx1] = stk_data_in;
        STK_POP:  sp_d = sp_q - SPW'(1);
        STK_DUP: begin
          mem_d[idx0] = mem_q[idx1];
          sp_d        = sp_q + SPW'(1);
        end
        STK_SWAP: begin
          mem_d[idx1] = mem_q[idx2];
          mem_d[idx2] = mem_q[idx1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sp_q  <= '0;
      arm_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      arm_q <= arm_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign stk_count    = sp_q;
  assign stk_empty    = (sp_q == '0);
  assign stk_full     = (sp_q == SP_FULL);
  assign stk_data_out = (sp_q == '0)       ? '0 : mem_q[idx1];
  assign stk_nos      = (sp_q < SPW'(2))   ? '0 : mem_q[idx2];

endmodule

// File: tb/tb_op_stack.sv
// Self-checking bench for op_stack: directed scenarios plus randomized ops
// against a queue-based reference model.
module tb_op_stack;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          stk_push, stk_pop, stk_dup, stk_swap;
  logic [DW-1:0] stk_data_in;
  logic [DW-1:0] stk_data_out, stk_nos;
  logic [CW-1:0] stk_count;
  logic          stk_empty, stk_full, stk_err;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model[$];

  always #5 clk = ~clk;

  op_stack #(.DATA_LEN(DW), .STK_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_dup(stk_dup), .stk_swap(stk_swap),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out), .stk_nos(stk_nos),
    .stk_count(stk_count), .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    stk_push = 0; stk_pop = 0; stk_dup = 0; stk_swap = 0; stk_data_in = '0;
    rstn = 0;
    tick; tick;
    rstn = 1;
    tick; tick;
    model.delete();
  endtask

  // One-cycle request, then one idle cycle so the next request is a fresh edge.
  task automatic pulse(input bit p, input bit o, input bit d, input bit s, input logic [DW-1:0] din);
    stk_push = p; stk_pop = o; stk_dup = d; stk_swap = s; stk_data_in = din;
    tick;
    stk_push = 0; stk_pop = 0; stk_dup = 0; stk_swap = 0;
    tick;
  endtask

  function automatic bit legal(input bit p, input bit o, input bit d, input bit s);
    int n = model.size();
    if (p && o) return 1'b1;
    if (p) return n < DEPTH;
    if (o) return n > 0;
    if (d) return (n > 0) && (n < DEPTH);
    if (s) return n >= 2;
    return 1'b1;
  endfunction

  task automatic model_apply(input bit p, input bit o, input bit d, input bit s, input logic [DW-1:0] din);
    int n = model.size();
    logic [DW-1:0] t;
    if (p && o) begin
      if (n == 0) model.push_back(din);
      else        model[n-1] = din;
    end else if (p) model.push_back(din);
    else if (o) void'(model.pop_back());
    else if (d) model.push_back(model[n-1]);
    else if (s) begin
      t = model[n-1]; model[n-1] = model[n-2]; model[n-2] = t;
    end
  endtask

  function automatic logic [DW-1:0] exp_top();
    return (model.size() == 0) ? '0 : model[model.size()-1];
  endfunction

  function automatic logic [DW-1:0] exp_nos();
    return (model.size() < 2) ? '0 : model[model.size()-2];
  endfunction

  task automatic test_reset;
    do_reset();
    checks++; if (stk_count !== 0)    begin errors++; $display("FAIL reset_count got %0d want 0", stk_count); end
    checks++; if (stk_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", stk_empty); end
    checks++; if (stk_full !== 1'b0)  begin errors++; $display("FAIL reset_full got %b want 0", stk_full); end
    checks++; if (stk_data_out !== 0 || stk_nos !== 0)
      begin errors++; $display("FAIL reset_data got top=%h nos=%h want 00/00", stk_data_out, stk_nos); end
    checks++; if (stk_err !== 1'b0)   begin errors++; $display("FAIL reset_err got %b want 0", stk_err); end
  endtask

  task automatic test_push;
    do_reset();
    pulse(1, 0, 0, 0, 8'h12);
    pulse(1, 0, 0, 0, 8'h34);
    pulse(1, 0, 0, 0, 8'h56);
    checks++; if (stk_count !== 3) begin errors++; $display("FAIL push_count got %0d want 3", stk_count); end
    checks++; if (stk_data_out !== 8'h56 || stk_nos !== 8'h34)
      begin errors++; $display("FAIL push_data got top=%h nos=%h want 56/34", stk_data_out, stk_nos); end
    checks++; if (stk_empty !== 1'b0) begin errors++; $display("FAIL push_empty got %b want 0", stk_empty); end
  endtask

  task automatic test_pop_hold;
    do_reset();
    pulse(1, 0, 0, 0, 8'h12);
    pulse(1, 0, 0, 0, 8'h34);
    stk_pop = 1;
    @(negedge clk);
    checks++; if (stk_data_out !== 8'h34 || stk_count !== 2)
      begin errors++; $display("FAIL pop_sampled got top=%h count=%0d want 34/2", stk_data_out, stk_count); end
    tick;
    checks++; if (stk_count !== 1 || stk_data_out !== 8'h12)
      begin errors++; $display("FAIL pop_effect got count=%0d top=%h want 1/12", stk_count, stk_data_out); end
    tick;
    stk_pop = 1'bz;
    tick; tick; tick;
    checks++; if (stk_count !== 1 || stk_data_out !== 8'h12 || stk_nos !== 8'h00)
      begin errors++; $display("FAIL pop_once got count=%0d top=%h nos=%h want 1/12/00", stk_count, stk_data_out, stk_nos); end
    stk_pop = 0;
    tick;
  endtask

  task automatic test_replace;
    do_reset();
    pulse(1, 0, 0, 0, 8'h01);
    pulse(1, 1, 0, 0, 8'h7F);
    checks++; if (stk_count !== 1 || stk_data_out !== 8'h7F)
      begin errors++; $display("FAIL replace got count=%0d top=%h want 1/7f", stk_count, stk_data_out); end
    do_reset();
    pulse(1, 1, 0, 0, 8'h33);
    checks++; if (stk_count !== 1 || stk_data_out !== 8'h33 || stk_err !== 1'b0)
      begin errors++; $display("FAIL replace_empty got count=%0d top=%h err=%b want 1/33/0", stk_count, stk_data_out, stk_err); end
  endtask

  task automatic test_dup_swap;
    do_reset();
    pulse(1, 0, 0, 0, 8'h05);
    pulse(1, 0, 0, 0, 8'h09);
    pulse(0, 0, 1, 0, 8'h00);
    checks++; if (stk_count !== 3 || stk_data_out !== 8'h09 || stk_nos !== 8'h09)
      begin errors++; $display("FAIL dup got count=%0d top=%h nos=%h want 3/09/09", stk_count, stk_data_out, stk_nos); end
    pulse(0, 0, 0, 1, 8'h00);
    checks++; if (stk_count !== 3 || stk_data_out !== 8'h09 || stk_nos !== 8'h09)
      begin errors++; $display("FAIL swap_equal got count=%0d top=%h nos=%h want 3/09/09", stk_count, stk_data_out, stk_nos); end
    do_reset();
    pulse(1, 0, 0, 0, 8'h0B);
    pulse(1, 0, 0, 0, 8'h0A);
    pulse(0, 0, 0, 1, 8'h00);
    checks++; if (stk_data_out !== 8'h0B || stk_nos !== 8'h0A)
      begin errors++; $display("FAIL swap got top=%h nos=%h want 0b/0a", stk_data_out, stk_nos); end
    pulse(0, 0, 1, 1, 8'h00);
    checks++; if (stk_count !== 3 || stk_data_out !== 8'h0B || stk_nos !== 8'h0B)
      begin errors++; $display("FAIL dup_over_swap got count=%0d top=%h nos=%h want 3/0b/0b", stk_count, stk_data_out, stk_nos); end
  endtask

  task automatic test_full;
    do_reset();
    for (int i = 0; i < DEPTH; i++) pulse(1, 0, 0, 0, 8'(i * 3 + 1));
    checks++; if (stk_count !== 16 || stk_full !== 1'b1 || stk_data_out !== 8'd46)
      begin errors++; $display("FAIL fill got count=%0d full=%b top=%h want 16/1/2e", stk_count, stk_full, stk_data_out); end
    pulse(1, 0, 0, 0, 8'hAA);
`ifdef STK_GUARD_EN
    checks++; if (stk_count !== 16 || stk_data_out !== 8'd46 || stk_err !== 1'b1)
      begin errors++; $display("FAIL overflow got count=%0d top=%h err=%b want 16/2e/1", stk_count, stk_data_out, stk_err); end
    do_reset();
    checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", stk_err); end
    pulse(0, 1, 0, 0, 8'h00);
    checks++; if (stk_count !== 0 || stk_err !== 1'b1)
      begin errors++; $display("FAIL underflow got count=%0d err=%b want 0/1", stk_count, stk_err); end
`else
    checks++; if (stk_count !== 17 || stk_full !== 1'b0 || stk_data_out !== 8'hAA || stk_err !== 1'b0)
      begin errors++; $display("FAIL overflow_wrap got count=%0d full=%b top=%h err=%b want 17/0/aa/0", stk_count, stk_full, stk_data_out, stk_err); end
    do_reset();
    pulse(0, 1, 0, 0, 8'h00);
    checks++; if (stk_count !== 31 || stk_err !== 1'b0)
      begin errors++; $display("FAIL underflow_wrap got count=%0d err=%b want 31/0", stk_count, stk_err); end
`endif
  endtask

  task automatic test_reset_held;
    do_reset();
    pulse(1, 0, 0, 0, 8'h21);
    pulse(1, 0, 0, 0, 8'h22);
    stk_pop = 1;
    tick;
    #2 rstn = 0;
    #1;
    checks++; if (stk_count !== 0 || stk_empty !== 1'b1 || stk_data_out !== 0)
      begin errors++; $display("FAIL async_reset got count=%0d empty=%b top=%h want 0/1/00", stk_count, stk_empty, stk_data_out); end
    tick; tick;
    rstn = 1;
    tick; tick; tick;
    checks++; if (stk_count !== 0 || stk_empty !== 1'b1 || stk_err !== 1'b0)
      begin errors++; $display("FAIL held_through_reset got count=%0d empty=%b err=%b want 0/1/0", stk_count, stk_empty, stk_err); end
    stk_pop = 0;
    tick;
    pulse(1, 0, 0, 0, 8'h44);
    pulse(0, 1, 0, 0, 8'h00);
    checks++; if (stk_count !== 0 || stk_empty !== 1'b1)
      begin errors++; $display("FAIL pop_after_reset got count=%0d empty=%b want 0/1", stk_count, stk_empty); end
  endtask

  task automatic test_back_to_back;
    bit p, o, d, s;
    logic [DW-1:0] din;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      p = ($urandom_range(0, 1) == 0);
      o = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) == 0);
      din = 8'($urandom);
      if (!legal(p, o, d, s)) begin p = 0; o = 0; d = 0; s = 0; end
      model_apply(p, o, d, s, din);
      pulse(p, o, d, s, din);
      checks++; if (stk_count !== CW'(model.size()))
        begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", i, stk_count, model.size()); end
      checks++; if (stk_data_out !== exp_top() || stk_nos !== exp_nos())
        begin errors++; $display("FAIL rand_data[%0d] got top=%h nos=%h want %h/%h", i, stk_data_out, stk_nos, exp_top(), exp_nos()); end
      checks++; if (stk_empty !== (model.size() == 0) || stk_full !== (model.size() == DEPTH) || stk_err !== 1'b0)
        begin errors++; $display("FAIL rand_flags[%0d] got empty=%b full=%b err=%b size=%0d", i, stk_empty, stk_full, stk_err, model.size()); end
    end
  endtask

  initial begin
    rstn = 0;
    stk_push = 0; stk_pop = 0; stk_dup = 0; stk_swap = 0; stk_data_in = '0;
    test_reset();
    test_push();
    test_pop_hold();
    test_replace();
    test_dup_swap();
    test_full();
    test_reset_held();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
